// File: rtl/debug_bridge_uart.sv
// debug_bridge_uart
// Bridges single 32-bit client transactions onto an 8N1 UART link to a host.
// A write streams the latched word to the host as four bytes, MSB first.
// A read collects four bytes from the host into q, first byte in q[31:24].
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   req          transaction request, held high until ack
//   wr           1 = write (client to host), 0 = read (host to client)
//   d[31:0]      client write data, latched when the request is accepted
//   q[31:0]      read data, changes only while a read is collecting bytes
//   ack          one-cycle transaction-complete pulse
//   rxd          host UART receive line (asynchronous, idle high)
//   txd          host UART transmit line (idle high)
//   framing_err  sticky: a received stop bit was sampled low
module debug_bridge_uart #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] d,
    output logic [31:0] q,
    output logic        ack,
    input  logic        rxd,
    output logic        txd,
    output logic        framing_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        ACK  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_next_s;

    logic           rxd_meta_r;
    logic           rxd_sync_r;
    logic           rxd_prev_r;
    logic           rx_fall_s;
    logic           rx_busy_r;
    logic [3:0]     rx_bit_r;
    logic [CW-1:0]  rx_cnt_r;
    logic [7:0]     rx_shift_r;
    logic           rx_valid_r;
    logic           framing_err_r;

    logic           tx_active_r;
    logic [3:0]     tx_bit_r;
    logic [CW-1:0]  tx_cnt_r;
    logic [8:0]     tx_frame_r;
    logic           txd_r;
    logic           tx_done_s;
    logic           tx_start_s;
    logic [7:0]     tx_byte_s;

    logic [1:0]     byte_cnt_r;
    logic [23:0]    wdata_r;
    logic [31:0]    q_r;
    logic           ack_r;

    assign q           = q_r;
    assign ack         = ack_r;
    assign txd         = txd_r;
    assign framing_err = framing_err_r;

    assign rx_fall_s = rxd_prev_r & ~rxd_sync_r;
    // Last clock of the stop bit of the byte currently on the line.
    assign tx_done_s = tx_active_r && (tx_cnt_r == BIT_LAST) && (tx_bit_r == 4'd9);

    // Two-flop synchroniser on rxd plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // UART receiver: rx_bit_r 0 = half-bit start check, 1..8 = data, 9 = stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_busy_r     <= 1'b0;
            rx_bit_r      <= 4'd0;
            rx_cnt_r      <= '0;
            rx_shift_r    <= 8'h00;
            rx_valid_r    <= 1'b0;
            framing_err_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if (!rx_busy_r) begin
                if (rx_fall_s) begin
                    rx_busy_r <= 1'b1;
                    rx_bit_r  <= 4'd0;
                    rx_cnt_r  <= '0;
                end
            end else if (rx_cnt_r == ((rx_bit_r == 4'd0) ? HALF_LAST : BIT_LAST)) begin
                rx_cnt_r <= '0;
                if (rx_bit_r == 4'd0) begin
                    // A start bit that has gone high again was only a glitch.
                    if (rxd_sync_r) begin
                        rx_busy_r <= 1'b0;
                    end else begin
                        rx_bit_r <= 4'd1;
                    end
                end else if (rx_bit_r < 4'd9) begin
                    rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
                    rx_bit_r   <= rx_bit_r + 4'd1;
                end else begin
                    // Back to start-bit search right away so zero-idle streams work.
                    rx_busy_r <= 1'b0;
                    if (rxd_sync_r) begin
                        rx_valid_r <= 1'b1;
                    end else begin
                        framing_err_r <= 1'b1;
                    end
                end
            end else begin
                rx_cnt_r <= rx_cnt_r + CW'(1);
            end
        end
    end

    // UART transmitter: start bit, 8 data bits LSB first, stop bit; a new
    // byte loaded on the last stop-bit clock follows with no idle gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_active_r <= 1'b0;
            tx_bit_r    <= 4'd0;
            tx_cnt_r    <= '0;
            tx_frame_r  <= 9'h1FF;
            txd_r       <= 1'b1;
        end else if (tx_start_s) begin
            tx_active_r <= 1'b1;
            tx_bit_r    <= 4'd0;
            tx_cnt_r    <= '0;
            tx_frame_r  <= {1'b1, tx_byte_s};
            txd_r       <= 1'b0;
        end else if (tx_active_r) begin
            if (tx_cnt_r == BIT_LAST) begin
                tx_cnt_r <= '0;
                if (tx_bit_r == 4'd9) begin
                    tx_active_r <= 1'b0;
                    tx_bit_r    <= 4'd0;
                    txd_r       <= 1'b1;
                end else begin
                    txd_r      <= tx_frame_r[0];
                    tx_frame_r <= {1'b1, tx_frame_r[8:1]};
                    tx_bit_r   <= tx_bit_r + 4'd1;
                end
            end else begin
                tx_cnt_r <= tx_cnt_r + CW'(1);
            end
        end else begin
            txd_r <= 1'b1;
        end
    end

    // Transaction FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Transaction FSM next state and transmitter load requests.
    always_comb begin
        state_next_s = state_r;
        tx_start_s   = 1'b0;
        tx_byte_s    = 8'h00;
        case (state_r)
            IDLE: begin
                if (req) begin
                    if (wr) begin
                        state_next_s = WR;
                        tx_start_s   = 1'b1;
                        tx_byte_s    = d[31:24];
                    end else begin
                        state_next_s = RD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD: begin
                if (rx_valid_r && (byte_cnt_r == 2'd3)) begin
                    state_next_s = ACK;
                end else begin
                    state_next_s = RD;
                end
            end
            WR: begin
                if (tx_done_s) begin
                    if (byte_cnt_r == 2'd3) begin
                        state_next_s = ACK;
                    end else begin
                        tx_start_s = 1'b1;
                        tx_byte_s  = wdata_r[23:16];
                    end
                end else begin
                    state_next_s = WR;
                end
            end
            ACK: begin
                state_next_s = DONE;
            end
            DONE: begin
                // Holding req past ack must not re-trigger a transaction.
                if (!req) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Transaction datapath: write-data latch, byte counter, read data, ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_r <= 2'd0;
            wdata_r    <= 24'h000000;
            q_r        <= 32'h00000000;
            ack_r      <= 1'b0;
        end else begin
            ack_r <= (state_next_s == ACK);
            case (state_r)
                IDLE: begin
                    if (req) begin
                        byte_cnt_r <= 2'd0;
                        // d[31:24] goes straight to the transmitter.
                        wdata_r    <= d[23:0];
                    end
                end
                RD: begin
                    if (rx_valid_r) begin
                        q_r <= {q_r[23:0], rx_shift_r};
                        if (byte_cnt_r != 2'd3) begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end
                end
                WR: begin
                    if (tx_done_s) begin
                        wdata_r <= {wdata_r[15:0], 8'h00};
                        if (byte_cnt_r != 2'd3) begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_bridge_uart.sv
// Testbench for debug_bridge_uart with CLKS_PER_BIT = 4.
// A table of transactions is applied in a loop; expected host-bound frames and
// expected q values are queued when each transaction is driven and compared
// when the DUT produces the frames / the ack. Hand-written sequences cover
// framing errors, glitches, idle-time bytes and reset in mid-write.
module tb_debug_bridge_uart;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] d = 32'h0;
    logic        rxd = 1'b1;
    logic [31:0] q;
    logic        ack;
    logic        txd;
    logic        framing_err;

    int checks = 0;
    int errors = 0;

    logic [9:0]  got_tx_q[$];
    logic [9:0]  exp_tx_q[$];
    logic [31:0] exp_q_q[$];
    logic [31:0] model_q = 32'h0;
    logic [9:0]  mon_frame;

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
        logic [31:0] expv;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    debug_bridge_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .wr(wr),
        .d(d),
        .q(q),
        .ack(ack),
        .rxd(rxd),
        .txd(txd),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    // Host-side receiver model: decodes every frame seen on txd.
    initial begin
        forever begin
            @(negedge txd);
            repeat (CPB / 2) @(negedge clk);
            mon_frame[0] = txd;
            for (int i = 1; i < 10; i++) begin
                repeat (CPB) @(negedge clk);
                mon_frame[i] = txd;
            end
            got_tx_q.push_back(mon_frame);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(CPB);
        end
        rxd = stop_bit;
        cyc(CPB);
        rxd = 1'b1;
    endtask

    task automatic glitch();
        rxd = 1'b0;
        cyc(2);
        rxd = 1'b1;
        cyc(8);
    endtask

    task automatic wait_ack();
        logic        seen;
        logic [31:0] e;
        seen = 1'b0;
        e = exp_q_q.pop_front();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("ack_seen", {31'b0, seen}, 32'd1);
        if (seen) begin
            check("q_at_ack", q, e);
            @(negedge clk);
            check("ack_one_cycle", {31'b0, ack}, 32'd0);
        end
    endtask

    task automatic drain_tx();
        logic [9:0] g;
        logic [9:0] e;
        check("tx_frame_count", got_tx_q.size(), exp_tx_q.size());
        while (exp_tx_q.size() > 0 && got_tx_q.size() > 0) begin
            g = got_tx_q.pop_front();
            e = exp_tx_q.pop_front();
            check("tx_frame", {22'b0, g}, {22'b0, e});
        end
        exp_tx_q.delete();
        got_tx_q.delete();
    endtask

    // mode 1: glitch, then 0x55 with a low stop bit, before the real bytes.
    task automatic run_txn(input logic is_wr, input logic [31:0] data,
                           input logic [31:0] expv, input int hold, input int mode);
        int extra_ack;
        int txd_low;
        req = 1'b1;
        wr  = is_wr;
        d   = data;
        if (is_wr) begin
            for (int i = 3; i >= 0; i--) begin
                exp_tx_q.push_back({1'b1, expv[8*i +: 8], 1'b0});
            end
            exp_q_q.push_back(model_q);
        end else begin
            exp_q_q.push_back(expv);
            model_q = expv;
        end
        fork
            begin
                cyc(2);
                d = ~data;
                if (!is_wr) begin
                    if (mode == 1) begin
                        glitch();
                        send_byte(8'h55, 1'b0);
                        cyc(2 * CPB);
                        check("framing_err_set", {31'b0, framing_err}, 32'd1);
                    end
                    for (int i = 3; i >= 0; i--) begin
                        send_byte(data[8*i +: 8], 1'b1);
                    end
                end
            end
            wait_ack();
        join
        extra_ack = 0;
        txd_low   = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ack === 1'b1) extra_ack++;
            if (txd !== 1'b1) txd_low++;
        end
        if (hold > 0) begin
            check("no_second_ack", extra_ack, 32'd0);
            check("no_second_tx", txd_low, 32'd0);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        cyc(3);
        check("q_hold", q, model_q);
        drain_tx();
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h12345678, 32'h12345678, 0};
        vecs[1] = '{1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        vecs[2] = '{1'b1, 32'h00FFA55A, 32'h00FFA55A, 5};
        vecs[3] = '{1'b1, 32'h80000001, 32'h80000001, 0};
        vecs[4] = '{1'b0, 32'h01028040, 32'h01028040, 5};
        vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_q", q, 32'h0);
        check("reset_ack", {31'b0, ack}, 32'd0);
        check("reset_txd", {31'b0, txd}, 32'd1);
        check("reset_ferr", {31'b0, framing_err}, 32'd0);
        #2;
        reset = 1'b0;
        cyc(2);

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].is_wr, vecs[v].data, vecs[v].expv, vecs[v].hold, 0);
        end

        // Short low glitch while idle must not look like a byte.
        glitch();
        cyc(20);
        check("glitch_idle_ferr", {31'b0, framing_err}, 32'd0);

        // A good byte while idle is dropped; the following read is exact.
        send_byte(8'h3C, 1'b1);
        cyc(8);
        check("idle_byte_q", q, model_q);
        run_txn(1'b0, 32'hA5C30F96, 32'hA5C30F96, 0, 0);

        // Bad stop bit plus glitch inside a read.
        run_txn(1'b0, 32'hF00DCAFE, 32'hF00DCAFE, 0, 1);
        check("framing_err_sticky", {31'b0, framing_err}, 32'd1);

        // Reset during bit 2 (a 0) of the second byte of a write.
        req = 1'b1;
        wr  = 1'b1;
        d   = 32'hA1B2C3D4;
        cyc(54);
        check("txd_low_before_reset", {31'b0, txd}, 32'd0);
        #2;
        reset = 1'b1;
        req   = 1'b0;
        #1;
        check("reset_mid_txd", {31'b0, txd}, 32'd1);
        check("reset_mid_ack", {31'b0, ack}, 32'd0);
        check("reset_mid_q", q, 32'h0);
        check("reset_mid_ferr", {31'b0, framing_err}, 32'd0);
        model_q = 32'h0;
        cyc(2);
        #2;
        reset = 1'b0;
        begin
            int acks_after;
            acks_after = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (ack === 1'b1) acks_after++;
            end
            check("abort_no_ack", acks_after, 32'd0);
        end
        check("abort_first_frame_count", {31'b0, (got_tx_q.size() >= 1)}, 32'd1);
        if (got_tx_q.size() >= 1) begin
            check("abort_first_frame", {22'b0, got_tx_q[0]}, {22'b0, 1'b1, 8'hA1, 1'b0});
        end
        got_tx_q.delete();
        exp_tx_q.delete();
        @(posedge clk);
        #1;
        run_txn(1'b0, 32'h0BADF00D, 32'h0BADF00D, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
